spi_manchester_rx: RTL and testbench
====================================

Name: spi_manchester_rx

Overview:
Receiver for the team's serial byte link. It samples the transmitter's data, enable and forwarded clock lines in the local clock domain and decodes the half-cell bit encoding: a 1 is high then low, a 0 is low then high. It reassembles the bits LSB-first into bytes and presents each byte on a valid/ready handshake to the downstream consumer (hash/crypto datapath). It also flags encoding, framing and overrun errors.

Parameters:
DATA_W, 8, bits per word; LSB received first.
SYNC_STAGES, 2, flops in each input synchronizer chain; minimum 2.

Ports:
clk  in  1  local system clock; all logic on the rising edge.
rst  in  1  asynchronous reset, active-high.
in  in  1  serial data line from the transmitter.
en_in  in  1  transmitter enable; high while a word is being sent.
clk_in  in  1  forwarded transmitter clock; frequency at most clk/4.
out_data  out  DATA_W  received word.
out_valid  out  1  out_data holds an unconsumed word.
out_ready  in  1  consumer accepts the word when out_valid and out_ready are both high.
code_err  out  1  1-cycle pulse: the two half-cells of a bit were equal.
frame_err  out  1  1-cycle pulse: en_in fell mid-word.
overrun  out  1  1-cycle pulse: a word completed while out_valid was still high.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, the synchronizers and shift register are cleared.
- in, en_in and clk_in each pass through a SYNC_STAGES flop chain. Edge detector: sclk_rise is asserted when the synced clk_in is 1 and its previous value was 0.
- Sampling occurs only on sclk_rise cycles. Each bit takes 2 samples: h0 (first half) and h1 (second half).
- FSM states:
  - IDLE: bit_cnt=0. When synced en_in=1 and sclk_rise occurs, capture h0 and go to HALF2.
  - HALF1: on sclk_rise, capture h0 and go to HALF2.
  - HALF2: on sclk_rise, capture h1.
    - If h1==h0: pulse code_err and go to HUNT.
    - Otherwise shift h0 into bit position bit_cnt and increment bit_cnt. If bit_cnt reaches DATA_W go to DONE; else go to HALF1.
  - DONE: occupies 1 cycle. If out_valid=0 or out_ready=1 in this cycle, load out_data and set out_valid. Otherwise pulse overrun and discard the new word; out_data is unchanged. Then go to IDLE when synced en_in=0, or to HALF1 when en_in=1 (back-to-back words).
  - HUNT: ignore all samples until synced en_in=0, then go to IDLE.
- If synced en_in falls while in HALF1 or HALF2 with a partial word, pulse frame_err, discard the partial word and go to IDLE. A fall at bit_cnt=0 in HALF1 is not an error.
- Handshake: out_valid clears on the cycle after out_valid&&out_ready. DONE loading and consumer acceptance in the same cycle: the new word wins and out_valid stays 1.
- Latency: out_valid rises SYNC_STAGES+2 clk cycles after the pin-level clk_in rising edge that carries the last h1.
- Samples arriving when en_in=0 are ignored. bit_cnt is $clog2(DATA_W+1) bits wide and is cleared on every entry to IDLE or HUNT.
- Reset mid-word: everything is cleared immediately and no error pulse is produced.

Optional Feature:
SPI_RX_PARITY_EN
- Defined: after the DATA_W data bits, one additional Manchester-coded even-parity bit is received (state PAR between HALF2 and DONE, using the same half-cell rules). The parity bit makes the 1-count of data plus parity even. On mismatch, a parity_err output pulses for 1 cycle, the word is dropped, and the FSM goes to HUNT. The parity_err port exists only when the macro is defined.
- Undefined: the word completes after DATA_W bits exactly as described above.

Test Plan:
- Send 0xA5 LSB-first, halves 10 01 10 01 01 10 01 10, out_ready=1: out_valid pulses once, out_data=0xA5, and no error outputs assert.
- Send 0x3C then 0xC3 back-to-back with out_ready=0: first word is held as 0x3C with out_valid=1, overrun pulses once, and out_data stays 0x3C. Then raise out_ready: out_valid clears the next cycle.
- Send 0x0F with bit 3 halves forced to 11: code_err pulses at the 8th sample, no out_valid, and the remaining samples are ignored until en_in falls. A subsequent 0x55 is received correctly.
- Drop en_in after 4 bits of 0xFF: frame_err pulses and no out_valid. A following 0x81 is received correctly.
- Assert rst after 5 bits of 0x99: all outputs are 0 the same cycle. After release, 0x42 is received with out_data=0x42.
- With SPI_RX_PARITY_EN: 0x07 with parity 1 is accepted. 0x07 with parity 0 causes a parity_err pulse and no out_valid.

Source files
------------

// File: rtl/spi_manchester_rx.sv
// spi_manchester_rx: serial byte receiver with half-cell bit decoding.
// Samples data/enable/forwarded clock through synchronizers, decodes
// bit pairs (1 = high,low ; 0 = low,high), assembles words LSB-first and
// presents them on a valid/ready handshake. Flags code, frame and overrun
// errors as 1-cycle pulses.
// Optional macro SPI_RX_PARITY_EN: adds a trailing even-parity bit and a
// parity_err output.
module spi_manchester_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  input  logic              en_in,
  input  logic              clk_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              code_err,
  output logic              frame_err,
  output logic              overrun
`ifdef SPI_RX_PARITY_EN
  ,
  output logic              parity_err
`endif
);
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HALF1, S_HALF2, S_DONE, S_HUNT, S_PAR1, S_PAR2
  } state_e;

  logic [SYNC_STAGES-1:0] in_sync_q, en_sync_q, ck_sync_q;
  logic                   ck_prev_q;
  logic                   in_s, en_s, ck_s, sclk_rise;

  state_e            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              h0_q, h0_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              code_err_q, code_err_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
`ifdef SPI_RX_PARITY_EN
  logic              parity_err_q, parity_err_d;
`endif

  assign in_s      = in_sync_q[SYNC_STAGES-1];
  assign en_s      = en_sync_q[SYNC_STAGES-1];
  assign ck_s      = ck_sync_q[SYNC_STAGES-1];
  assign sclk_rise = ck_s & ~ck_prev_q;

  // Input synchronizer chains plus previous synced clock for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_sync_q <= '0;
      en_sync_q <= '0;
      ck_sync_q <= '0;
      ck_prev_q <= 1'b0;
    end else begin
      in_sync_q <= {in_sync_q[SYNC_STAGES-2:0], in};
      en_sync_q <= {en_sync_q[SYNC_STAGES-2:0], en_in};
      ck_sync_q <= {ck_sync_q[SYNC_STAGES-2:0], clk_in};
      ck_prev_q <= ck_s;
    end
  end

  // Decoder FSM next-state, word assembly, handshake and error pulses
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    h0_d        = h0_q;
    shreg_d     = shreg_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    code_err_d  = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef SPI_RX_PARITY_EN
    parity_err_d = 1'b0;
`endif
    // Consumer acceptance; a word loaded in DONE below overrides this
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (en_s && sclk_rise) begin
          h0_d    = in_s;
          state_d = S_HALF2;
        end
      end
      S_HALF1: begin
        if (!en_s) begin
          // Between words (nothing received yet) an enable drop is legal
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          state_d     = S_IDLE;
        end else if (sclk_rise) begin
          h0_d    = in_s;
          state_d = S_HALF2;
        end
      end
      S_HALF2: begin
        if (!en_s) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = S_IDLE;
        end else if (sclk_rise) begin
          if (in_s == h0_q) begin
            code_err_d = 1'b1;
            bit_cnt_d  = '0;
            state_d    = S_HUNT;
          end else begin
            for (int i = 0; i < DATA_W; i++)
              if (bit_cnt_q == CW'(i)) shreg_d[i] = h0_q;
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == CW'(DATA_W - 1))
`ifdef SPI_RX_PARITY_EN
              state_d = S_PAR1;
`else
              state_d = S_DONE;
`endif
            else
              state_d = S_HALF1;
          end
        end
      end
`ifdef SPI_RX_PARITY_EN
      S_PAR1: begin
        if (!en_s) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = S_IDLE;
        end else if (sclk_rise) begin
          h0_d    = in_s;
          state_d = S_PAR2;
        end
      end
      S_PAR2: begin
        if (!en_s) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = S_IDLE;
        end else if (sclk_rise) begin
          if (in_s == h0_q) begin
            code_err_d = 1'b1;
            bit_cnt_d  = '0;
            state_d    = S_HUNT;
          end else if ((^shreg_q) ^ h0_q) begin
            // Odd total 1-count: drop the word
            parity_err_d = 1'b1;
            bit_cnt_d    = '0;
            state_d      = S_HUNT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
`endif
      S_DONE: begin
        if (!out_valid_q || out_ready) begin
          out_data_d  = shreg_q;
          out_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        bit_cnt_d = '0;
        state_d   = en_s ? S_HALF1 : S_IDLE;
      end
      S_HUNT: begin
        bit_cnt_d = '0;
        if (!en_s) state_d = S_IDLE;
      end
      default: begin
        bit_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      h0_q        <= 1'b0;
      shreg_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SPI_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      h0_q        <= h0_d;
      shreg_q     <= shreg_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      code_err_q  <= code_err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef SPI_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign code_err  = code_err_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef SPI_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_spi_manchester_rx.sv
// tb_spi_manchester_rx: directed + randomized bench for spi_manchester_rx.
// Expected outcomes come from a word-level decode model of the line code.
module tb_spi_manchester_rx;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
`ifdef SPI_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_pin = 1'b0;
  logic              en_in = 1'b0;
  logic              clk_in = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, code_err, frame_err, overrun;
`ifdef SPI_RX_PARITY_EN
  logic              parity_err;
`endif

  spi_manchester_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .in(in_pin), .en_in(en_in), .clk_in(clk_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .code_err(code_err), .frame_err(frame_err), .overrun(overrun)
`ifdef SPI_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  // Event monitor: counts pulses, valid rises and accepted words
  int n_code = 0, n_frame = 0, n_ovr = 0, n_par = 0, n_vrise = 0, n_acc = 0;
  int vrise_cyc = 0;
  logic [DATA_W-1:0] acc_mem [0:255];
  logic vprev = 1'b0;
  always @(negedge clk) begin
    if (code_err)  n_code++;
    if (frame_err) n_frame++;
    if (overrun)   n_ovr++;
`ifdef SPI_RX_PARITY_EN
    if (parity_err) n_par++;
`endif
    if (out_valid && !vprev) begin
      n_vrise++;
      vrise_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      acc_mem[n_acc % 256] = out_data;
      n_acc++;
    end
    vprev = out_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int s_code, s_frame, s_ovr, s_par, s_vrise, s_acc;
  int last_rise = 0;

  task automatic snap();
    s_code = n_code; s_frame = n_frame; s_ovr = n_ovr;
    s_par = n_par; s_vrise = n_vrise; s_acc = n_acc;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] last_acc();
    if (n_acc == 0) return 'x;
    return acc_mem[(n_acc - 1) % 256];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One half-cell: data settles, forwarded clock rises, then falls (clk/4)
  task automatic half(input logic b);
    in_pin = b;
    tick(2);
    clk_in = 1'b1;
    last_rise = cyc;
    tick(2);
    clk_in = 1'b0;
  endtask

  // Sends nbits data bits LSB-first; bad_bit gets equal halves; full words
  // get the trailing parity bit when parity is built in
  task automatic send_word(input logic [DATA_W-1:0] d, input int nbits,
                           input int bad_bit, input bit par_flip);
    logic h0, h1;
    int nb;
    logic [DATA_W:0] w;
    w  = {(^d) ^ par_flip, d};
    nb = (PAR && nbits == DATA_W) ? DATA_W + 1 : nbits;
    for (int i = 0; i < nb; i++) begin
      h0 = w[i];
      h1 = ~w[i];
      if (i == bad_bit) h1 = h0;
      half(h0);
      half(h1);
    end
  endtask

  task automatic xfer(input logic [DATA_W-1:0] d, input int nbits, input int bad_bit,
                      input bit par_flip, input bit keep_en);
    if (!en_in) begin
      en_in = 1'b1;
      tick(4);
    end
    send_word(d, nbits, bad_bit, par_flip);
    if (!keep_en) begin
      tick(2);
      en_in = 1'b0;
      tick(10);
    end
  endtask

  // Word-level model: 0 word, 1 code error, 2 frame error
  function automatic int predict(input logic [DATA_W-1:0] d, input int nbits,
                                 input int bad_bit, output logic [DATA_W-1:0] word);
    logic [DATA_W-1:0] acc;
    acc  = '0;
    word = '0;
    for (int i = 0; i < nbits; i++) begin
      if (i == bad_bit) return 1;
      acc[i] = d[i];
    end
    word = acc;
    return (nbits == DATA_W) ? 0 : 2;
  endfunction

  initial begin
    logic [DATA_W-1:0] rd, mw;
    int mode, nb, bb, kind;

    // Reset state
    tick(3);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_code", code_err, 0);
    check("rst_frame", frame_err, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;
    tick(4);

    // Basic word, consumer always ready
    snap();
    out_ready = 1'b1;
    xfer(8'hA5, DATA_W, -1, 0, 0);
    check("a5_vrise", n_vrise - s_vrise, 1);
    check("a5_nacc", n_acc - s_acc, 1);
    check("a5_data", last_acc(), 8'hA5);
    check("a5_errs", (n_code - s_code) + (n_frame - s_frame) + (n_ovr - s_ovr) + (n_par - s_par), 0);
    check("a5_latency", vrise_cyc - last_rise, SYNC_STAGES + 2);
    check("a5_valid_clr", out_valid, 0);

    // Back-to-back words with consumer stalled: second word overruns
    snap();
    out_ready = 1'b0;
    xfer(8'h3C, DATA_W, -1, 0, 1);
    xfer(8'hC3, DATA_W, -1, 0, 0);
    check("b2b_valid", out_valid, 1);
    check("b2b_data", out_data, 8'h3C);
    check("b2b_ovr", n_ovr - s_ovr, 1);
    check("b2b_vrise", n_vrise - s_vrise, 1);
    out_ready = 1'b1;
    tick(1);
    check("b2b_valid_clr", out_valid, 0);
    check("b2b_acc", last_acc(), 8'h3C);
    tick(2);

    // Code error on bit 3, rest of word ignored
    snap();
    xfer(8'h0F, DATA_W, 3, 0, 0);
    check("code_pulse", n_code - s_code, 1);
    check("code_vrise", n_vrise - s_vrise, 0);
    check("code_frame", n_frame - s_frame, 0);
    snap();
    xfer(8'h55, DATA_W, -1, 0, 0);
    check("after_code_data", last_acc(), 8'h55);
    check("after_code_vrise", n_vrise - s_vrise, 1);

    // Enable drop mid-word
    snap();
    xfer(8'hFF, 4, -1, 0, 0);
    check("frame_pulse", n_frame - s_frame, 1);
    check("frame_vrise", n_vrise - s_vrise, 0);
    check("frame_code", n_code - s_code, 0);
    snap();
    xfer(8'h81, DATA_W, -1, 0, 0);
    check("after_frame_data", last_acc(), 8'h81);
    check("after_frame_errs", (n_frame - s_frame) + (n_code - s_code), 0);

    // Reset mid-word while a word is held
    out_ready = 1'b0;
    xfer(8'h5A, DATA_W, -1, 0, 0);
    check("pre_rst_valid", out_valid, 1);
    en_in = 1'b1;
    tick(4);
    send_word(8'h99, 5, -1, 0);
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_pulses", {code_err, frame_err, overrun}, 0);
    en_in = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(4);
    out_ready = 1'b1;
    snap();
    xfer(8'h42, DATA_W, -1, 0, 0);
    check("post_rst_data", last_acc(), 8'h42);
    check("post_rst_vrise", n_vrise - s_vrise, 1);
    check("post_rst_errs", (n_code - s_code) + (n_frame - s_frame) + (n_ovr - s_ovr), 0);

    // Randomized words, corrupted bits and truncations against the model
    for (int k = 0; k < 10; k++) begin
      rd   = DATA_W'($urandom);
      mode = $urandom_range(0, 2);
      nb   = DATA_W;
      bb   = -1;
      if (mode == 1) bb = $urandom_range(0, DATA_W - 1);
      if (mode == 2) nb = $urandom_range(1, DATA_W - 1);
      kind = predict(rd, nb, bb, mw);
      snap();
      xfer(rd, nb, bb, 0, 0);
      check("rnd_vrise", n_vrise - s_vrise, (kind == 0) ? 1 : 0);
      check("rnd_code", n_code - s_code, (kind == 1) ? 1 : 0);
      check("rnd_frame", n_frame - s_frame, (kind == 2) ? 1 : 0);
      if (kind == 0) check("rnd_data", last_acc(), mw);
    end

`ifdef SPI_RX_PARITY_EN
    snap();
    xfer(8'h07, DATA_W, -1, 0, 0);
    check("par_ok_vrise", n_vrise - s_vrise, 1);
    check("par_ok_data", last_acc(), 8'h07);
    check("par_ok_err", n_par - s_par, 0);
    snap();
    xfer(8'h07, DATA_W, -1, 1, 0);
    check("par_bad_err", n_par - s_par, 1);
    check("par_bad_vrise", n_vrise - s_vrise, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
